// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART bit timer: FSM state encoding,
// minimum divisor and frame-length calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // Per-frame settings captured when a start is accepted
  typedef struct packed {
    logic       rx;
    logic [3:0] n;
  } frame_cfg_t;

  // Start + data + optional parity + stop bits; always in 9..12
  function automatic logic [3:0] frame_len(input logic eight, input logic pen,
                                           input logic stop2);
    logic [3:0] len;
    len = 4'd1 + (eight ? 4'd8 : 4'd7) + {3'd0, pen} + (stop2 ? 4'd2 : 4'd1);
    return len;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Free-running divisor counter: ticks when it reaches target-1 and wraps to
// zero on that same cycle.
module uart_baud_div #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         hit_s;

  // Terminal-count decode of the registered counter
  always_comb begin
    hit_s = (cnt_q == (target - W'(1)));
    tick  = en & hit_s;
  end

  // Next counter value: clear, wrap on terminal count, or advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (hit_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_bit_timer.sv
// UART bit timer: produces bit-time-up pulses for one frame, at end of each
// bit (TX) or mid-bit (RX, via an initial half-bit phase).
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_W = 19,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             mode,
  input  logic             eight,
  input  logic             pen,
  input  logic             stop2,
  output logic             btu,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  frame_cfg_t       cfg_q, cfg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             busy_s;
  logic             tick_s;
  logic             last_s;
  logic             clr_s;
  logic [DIV_W-1:0] target_s;
  logic [DIV_W-1:0] div_clamp_s;
  logic [CNT_W-1:0] n_ext_s;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort wins over both start and the final tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = mode ? ST_HALF : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALF: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALF;
        end
      end
      ST_RUN: begin
        if (abort || last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and frame-end decode
  always_comb begin
    busy_s   = (state_q != ST_IDLE);
    accept_s = (state_q == ST_IDLE) & start & ~abort;
    n_ext_s  = CNT_W'(cfg_q.n);
    last_s   = tick_s & (idx_q == (n_ext_s - CNT_W'(1)));
    clr_s    = accept_s | abort;
  end

  // Half-bit phase only exists for RX; afterwards one full bit per tick
  always_comb begin
    if ((state_q == ST_HALF) && cfg_q.rx) begin
      target_s = div_q >> 1;
    end else begin
      target_s = div_q;
    end
  end

  // Configuration capture and bit index / done next-state
  always_comb begin
    div_clamp_s = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    cfg_d       = cfg_q;
    div_d       = div_q;
    idx_d       = idx_q;
    if (accept_s) begin
      cfg_d.rx = mode;
      cfg_d.n  = frame_len(eight, pen, stop2);
      div_d    = div_clamp_s;
      idx_d    = '0;
    end else if (tick_s && (idx_q != n_ext_s)) begin
      idx_d = idx_q + CNT_W'(1);
    end else begin
      idx_d = idx_q;
    end
    done_d = last_s & ~abort;
  end

  // Configuration, bit index and done registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q  <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  uart_baud_div #(
    .W(DIV_W)
  ) u_baud_div (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (busy_s),
    .target(target_s),
    .tick  (tick_s)
  );

  // Output drive
  always_comb begin
    btu     = tick_s;
    bit_idx = idx_q;
    busy    = busy_s;
    done    = done_q;
  end

endmodule

// File: tb/tb_uart_bit_timer.sv
// Scoreboard bench for uart_bit_timer: stimulus pushes expected btu/done/idle
// events computed from frame arithmetic; a negedge monitor pops and compares.
module tb_uart_bit_timer;

  localparam int DIV_W = 19;
  localparam int CNT_W = 4;
  localparam int EV_BTU  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_IDLE = 2;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic             mode = 1'b0;
  logic             eight = 1'b0;
  logic             pen = 1'b0;
  logic             stop2 = 1'b0;
  logic             btu;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             done;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t q[$];

  uart_bit_timer #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .baud_div(baud_div),
    .mode    (mode),
    .eight   (eight),
    .pen     (pen),
    .stop2   (stop2),
    .btu     (btu),
    .bit_idx (bit_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    q.push_back(e);
  endfunction

  // Reference model: the k-th bit time of a frame started at st ends at k*D
  // (TX) or D/2 + (k-1)*D (RX); returns the cycle at which the frame is over.
  function automatic int push_frame(input int st, input int d, input bit m,
                                    input bit e, input bit p, input bit s2,
                                    input int ab);
    int deff, n, t;
    deff = (d < 2) ? 2 : d;
    n    = 1 + (e ? 8 : 7) + (p ? 1 : 0) + (s2 ? 2 : 1);
    t    = 0;
    for (int k = 1; k <= n; k++) begin
      t = m ? (deff / 2 + (k - 1) * deff) : (k * deff);
      if (ab >= 0 && t > ab) break;
      push_ev(EV_BTU, st + t, k - 1);
    end
    if (ab >= 0) begin
      push_ev(EV_IDLE, st + ab + 1, 0);
      return st + ab + 1;
    end
    push_ev(EV_DONE, st + t + 1, n);
    return st + t + 1;
  endfunction

  // Monitor: compare every btu/done the DUT presents against the queue head
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("event_missed_at_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (btu) begin
        if (q.size() > 0 && q[0].kind == EV_BTU && q[0].cyc == cyc) begin
          check("btu_bit_idx", int'(bit_idx), q[0].idx);
          check("btu_busy", int'(busy), 1);
          void'(q.pop_front());
        end else begin
          check("unexpected_btu", int'(btu), 0);
        end
      end
      if (done) begin
        if (q.size() > 0 && q[0].kind == EV_DONE && q[0].cyc == cyc) begin
          check("done_bit_idx", int'(bit_idx), q[0].idx);
          check("done_busy", int'(busy), 0);
          void'(q.pop_front());
        end else begin
          check("unexpected_done", int'(done), 0);
        end
      end
      if (q.size() > 0 && q[0].kind == EV_IDLE && q[0].cyc == cyc) begin
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        void'(q.pop_front());
      end
    end
  end

  task automatic run_frame(input int d, input bit m, input bit e, input bit p,
                           input bit s2, input int ab, input bit midstart);
    int st, fin;
    @(negedge clk);
    baud_div = DIV_W'(d);
    mode = m; eight = e; pen = p; stop2 = s2;
    start = 1'b1;
    st  = cyc;
    fin = push_frame(st, d, m, e, p, s2, ab);
    while (cyc < fin) begin
      @(negedge clk);
      start    = midstart && (cyc == st + 3);
      abort    = (ab >= 0) && (cyc == st + ab);
      baud_div = DIV_W'($urandom_range(0, 40));
      mode = 1'($urandom); eight = 1'($urandom);
      pen  = 1'($urandom); stop2 = 1'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int st, f1, f2, d, ab;
    bit m, e, p, s2;

    #12;
    check("reset_btu", int'(btu), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bit_idx", int'(bit_idx), 0);
    @(negedge clk);
    reset = 1'b0;

    // TX 8N1 at D=10, then RX 8-bit parity two-stop at D=10
    run_frame(10, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_frame(10, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    // Abort at cycle 35 of a TX frame
    run_frame(10, 1'b0, 1'b1, 1'b0, 1'b0, 35, 1'b0);
    // Divisor below minimum, 7N1 frame, in both modes
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    // Start pulsed mid-frame is ignored
    run_frame(7, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);

    // Abort and start together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    push_ev(EV_IDLE, cyc + 1, 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;

    // Start held through the done cycle: back-to-back frames
    @(negedge clk);
    baud_div = DIV_W'(6); mode = 1'b0; eight = 1'b0; pen = 1'b1; stop2 = 1'b0;
    start = 1'b1;
    st = cyc;
    f1 = push_frame(st, 6, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    f2 = push_frame(f1, 6, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    while (cyc < f2) begin
      @(negedge clk);
      start = (cyc <= f1);
    end
    start = 1'b0;

    // Randomised frames, some aborted
    for (int i = 0; i < 12; i++) begin
      d  = $urandom_range(0, 24);
      m  = 1'($urandom); e = 1'($urandom); p = 1'($urandom); s2 = 1'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * ((d < 2) ? 2 : d)) : -1;
      run_frame(d, m, e, p, s2, ab, ab < 0);
    end

    // Reset mid-frame clears outputs asynchronously
    @(negedge clk);
    baud_div = DIV_W'(10); mode = 1'b0; eight = 1'b1; pen = 1'b0; stop2 = 1'b0;
    start = 1'b1;
    st = cyc;
    void'(push_frame(st, 10, 1'b0, 1'b1, 1'b0, 1'b0, -1));
    @(negedge clk);
    start = 1'b0;
    while (cyc < st + 23) @(negedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check("midreset_btu", int'(btu), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_bit_idx", int'(bit_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(10, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bit_timer.md
UART_BIT_TIMER -- requirements
Module: uart_bit_timer

Interface
REQ-001 SHALL have parameter DIV_W, default 19, meaning the width of the clocks-per-bit divisor.
REQ-002 SHALL have parameter CNT_W, default 4, meaning the width of the bit index (≥4).
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: start  input  1  request to begin a frame.
REQ-006 SHALL have port: abort  input  1  terminate the current frame.
REQ-007 SHALL have port: baud_div  input  DIV_W  clocks per bit time.
REQ-008 SHALL have port: mode  input  1  0 = TX (end-of-bit ticks), 1 = RX (mid-bit ticks).
REQ-009 SHALL have port: eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-010 SHALL have port: pen  input  1  parity bit present.
REQ-011 SHALL have port: stop2  input  1  two stop bits.
REQ-012 SHALL have port: btu  output  1  one-cycle bit-time-up pulse.
REQ-013 SHALL have port: bit_idx  output  CNT_W  number of btu pulses issued in the current frame.
REQ-014 SHALL have port: busy  output  1  frame in progress.
REQ-015 SHALL have port: done  output  1  one-cycle end-of-frame pulse.

Function
REQ-016 SHALL compute frame length N = 1 + (eight ? 8 : 7) + pen + (stop2 ? 2 : 1), range 9..12.
REQ-017 SHALL latch mode, eight, pen, stop2 and baud_div in the cycle start is accepted; changes during a frame SHALL be ignored.
REQ-018 SHALL treat a latched baud_div below 2 as 2.
REQ-019 SHALL implement states IDLE, HALF and RUN: IDLE→HALF on start when mode=1, IDLE→RUN on start when mode=0, HALF→RUN on its btu, RUN→IDLE on the Nth btu or on abort.
REQ-020 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-021 SHALL clear the divisor counter and bit_idx on start acceptance and assert busy from the next cycle.
REQ-022 SHALL increment the divisor counter every cycle while busy, pulse btu when it reaches target−1, and wrap it to 0 on that same cycle.
REQ-023 SHALL use target = baud_div>>1 in HALF and target = baud_div in RUN, so that TX issues btu D, 2D, …, N·D cycles after start and RX issues btu D/2, D/2+D, … cycles after start.
REQ-024 SHALL issue exactly N btu pulses per completed frame and increment bit_idx, saturating at N, in the cycle after each btu.
REQ-025 SHALL pulse done for one cycle in the cycle after the Nth btu, with busy low in that same cycle.
REQ-026 SHALL, on abort while busy, return to IDLE next cycle with no further btu and no done; bit_idx SHALL hold its value until the next start.
REQ-027 SHALL give abort priority over start in the same cycle.
REQ-028 SHALL accept a start asserted during the done cycle, making back-to-back frames possible.

Reset
REQ-029 SHALL, on reset, set the state to IDLE, clear the divisor counter, and drive btu=0, bit_idx=0, busy=0 and done=0.
REQ-030 SHALL, on reset asserted mid-frame, discard the frame without a done pulse and clear the latched configuration.

Structure
REQ-031 SHALL take the state enum, the minimum-divisor constant (2) and the frame-length function from shared package uart_pkg.
REQ-032 SHALL place the divisor counter and btu generation in sub-module uart_baud_div (ports clk, reset, clr, en, target, tick).

Verification
REQ-033 SHALL verify: baud_div=10, mode=0, eight=1, pen=0, stop2=0 → N=10, btu at 10, 20, …, 100 cycles after start, done at 101.
REQ-034 SHALL verify: baud_div=10, mode=1, eight=1, pen=1, stop2=1 → N=12, first btu at 5, then every 10 cycles, 12 btu pulses in total, done one cycle after the last btu.
REQ-035 SHALL verify: abort at cycle 35 of a TX frame with baud_div=10 → no btu after cycle 30, busy low at 36, done never asserted.
REQ-036 SHALL verify: baud_div=1 → btu every 2 cycles; eight=0, pen=0, stop2=0 → N=9.
REQ-037 SHALL verify: start held high through the done cycle → second frame starts immediately, and start pulsed mid-frame is ignored.
REQ-038 SHALL verify: reset asserted mid-frame → all outputs 0 asynchronously, and the next start behaves as from power-up.
